// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial transmitter, MSB-first, on an sclk/sdo/cs_n link.
// A word is captured on an accepted start, shifted out with sclk low for the first
// half of every bit and high for the second half, and the frame ends with a
// one-cycle DONE state that pulses done_tick.
// Optional feature: define SERIAL_TX_PARITY_EN to append an even-parity bit after the LSB.
module serial_word_tx #(
    parameter int bits = 23,
    parameter int div  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [bits-1:0] dd,
    output logic            busy,
    output logic            done_tick,
    output logic            sclk,
    output logic            sdo,
    output logic            cs_n
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = bits + 1;
`else
    localparam int NB = bits;
`endif
    localparam int DW = (div > 1) ? $clog2(div) : 1;
    localparam int CW = $clog2(NB + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(div - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NB - 1);
    localparam logic [CW-1:0] ALL_BITS = CW'(NB);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NB-1:0]   shreg_q, shreg_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   bitcnt_q, bitcnt_d;
    logic            sclk_q, sclk_d;
    logic [NB-1:0]   loadWord;

    // Word placed in the shift register at capture; the parity bit trails the LSB.
`ifdef SERIAL_TX_PARITY_EN
    assign loadWord = {dd, ^dd};
`else
    assign loadWord = dd;
`endif

    // State and datapath registers; reset forces every output to its idle value at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            div_q    <= '0;
            bitcnt_q <= '0;
            sclk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            sclk_q   <= sclk_d;
        end
    end

    // Next-state logic: the divider paces sclk, and each falling sclk toggle either
    // advances to the next bit or, after the final bit, ends the frame without shifting.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        sclk_d   = sclk_q;
        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                if (start) begin
                    shreg_d  = loadWord;
                    div_d    = '0;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        if (bitcnt_q == LAST_BIT) begin
                            bitcnt_d = ALL_BITS;
                            state_d  = DONE;
                        end else begin
                            shreg_d  = shreg_q << 1;
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                sclk_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                sclk_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        cs_n      = (state_q != SHIFT);
        busy      = (state_q != IDLE);
        done_tick = (state_q == DONE);
        sclk      = sclk_q;
        sdo       = (state_q == SHIFT) & shreg_q[NB-1];
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed bench for serial_word_tx (bits=23, div=2).
// A receiver model samples sdo on each rising sclk; frame contents, cycle timing,
// start handling, back-to-back framing and mid-frame reset are checked.
module tb_serial_word_tx;

    localparam int BITS = 23;
    localparam int DIV  = 2;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = BITS + 1;
`else
    localparam int NB = BITS;
`endif
    localparam int DONE_CYC = 1 + 2 * DIV * NB;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [BITS-1:0] dd    = '0;
    logic            busy, done_tick, sclk, sdo, cs_n;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] rxWord     = '0;
    int          riseCount  = 0;
    int          doneCount  = 0;
    int          riseBase, doneBase;

    serial_word_tx #(.bits(BITS), .div(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dd        (dd),
        .busy      (busy),
        .done_tick (done_tick),
        .sclk      (sclk),
        .sdo       (sdo),
        .cs_n      (cs_n)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Receiver model: shift in sdo on every rising sclk edge.
    always @(posedge sclk) begin
        rxWord    <= {rxWord[30:0], sdo};
        riseCount <= riseCount + 1;
    end

    // Count done_tick cycles mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (done_tick) doneCount <= doneCount + 1;
    end

    // Advance n cycles, landing 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present a word with start high for the capture cycle; returns in cycle 1.
    task automatic applyStimulus(input logic [BITS-1:0] word);
        dd    = word;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic logic [31:0] expectedFrame(input logic [BITS-1:0] word);
`ifdef SERIAL_TX_PARITY_EN
        return 32'({word, ^word});
`else
        return 32'(word);
`endif
    endfunction

    function automatic logic [31:0] receivedFrame();
        logic [31:0] mask;
        mask = (32'h1 << NB) - 32'h1;
        return rxWord & mask;
    endfunction

    initial begin
        // Reset state with the clock running.
        tick(3);
        checkOutput("rst_cs_n", 32'(cs_n), 32'd1);
        checkOutput("rst_sclk", 32'(sclk), 32'd0);
        checkOutput("rst_sdo", 32'(sdo), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done_tick), 32'd0);
        reset = 1'b1;
        tick(2);

        // Single frame timing and content.
        riseBase = riseCount;
        doneBase = doneCount;
        applyStimulus(23'h2A5A5A);
        checkOutput("f1_c1_cs_n", 32'(cs_n), 32'd0);
        checkOutput("f1_c1_busy", 32'(busy), 32'd1);
        checkOutput("f1_c1_sdo", 32'(sdo), 32'd0);
        checkOutput("f1_c1_sclk", 32'(sclk), 32'd0);
        tick(2);
        checkOutput("f1_c3_sclk", 32'(sclk), 32'd1);
        tick(DONE_CYC - 4);
        checkOutput("f1_predone", 32'(done_tick), 32'd0);
        tick(1);
        checkOutput("f1_done", 32'(done_tick), 32'd1);
        checkOutput("f1_done_cs_n", 32'(cs_n), 32'd1);
        checkOutput("f1_done_busy", 32'(busy), 32'd1);
        tick(1);
        checkOutput("f1_idle_busy", 32'(busy), 32'd0);
        checkOutput("f1_idle_done", 32'(done_tick), 32'd0);
        checkOutput("f1_word", receivedFrame(), expectedFrame(23'h2A5A5A));
        checkOutput("f1_rises", 32'(riseCount - riseBase), 32'(NB));
        checkOutput("f1_donecnt", 32'(doneCount - doneBase), 32'd1);

        // Start while busy is ignored and not queued.
        tick(2);
        doneBase = doneCount;
        applyStimulus(23'h7FFFFF);
        tick(39);
        dd    = 23'h000001;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(DONE_CYC - 40 + 1);
        checkOutput("ign_word", receivedFrame(), expectedFrame(23'h7FFFFF));
        tick(6);
        checkOutput("ign_busy", 32'(busy), 32'd0);
        checkOutput("ign_donecnt", 32'(doneCount - doneBase), 32'd1);

        // Back-to-back frames with start held high.
        doneBase = doneCount;
        dd    = 23'h123456;
        start = 1'b1;
        tick(DONE_CYC);
        checkOutput("b2b_done1", 32'(done_tick), 32'd1);
        checkOutput("b2b_word1", receivedFrame(), expectedFrame(23'h123456));
        tick(1);
        checkOutput("b2b_gap_busy", 32'(busy), 32'd0);
        checkOutput("b2b_gap_cs_n", 32'(cs_n), 32'd1);
        tick(1);
        checkOutput("b2b_f2_cs_n", 32'(cs_n), 32'd0);
        checkOutput("b2b_f2_busy", 32'(busy), 32'd1);
        tick(DONE_CYC - 1);
        checkOutput("b2b_done2", 32'(done_tick), 32'd1);
        checkOutput("b2b_word2", receivedFrame(), expectedFrame(23'h123456));
        start = 1'b0;
        tick(3);
        checkOutput("b2b_end_busy", 32'(busy), 32'd0);
        checkOutput("b2b_donecnt", 32'(doneCount - doneBase), 32'd2);

        // Mid-frame reset forces idle outputs immediately and suppresses done_tick.
        doneBase = doneCount;
        applyStimulus(23'h7FFFFF);
        tick(29);
        checkOutput("mr_pre_sdo", 32'(sdo), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mr_cs_n", 32'(cs_n), 32'd1);
        checkOutput("mr_sclk", 32'(sclk), 32'd0);
        checkOutput("mr_sdo", 32'(sdo), 32'd0);
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_done", 32'(done_tick), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(DONE_CYC + 5);
        checkOutput("mr_donecnt", 32'(doneCount - doneBase), 32'd0);
        checkOutput("mr_idle_busy", 32'(busy), 32'd0);
        doneBase = doneCount;
        riseBase = riseCount;
        applyStimulus(23'h0000FF);
        tick(DONE_CYC - 1);
        checkOutput("mr_f_done", 32'(done_tick), 32'd1);
        tick(1);
        checkOutput("mr_f_word", receivedFrame(), expectedFrame(23'h0000FF));
        checkOutput("mr_f_rises", 32'(riseCount - riseBase), 32'(NB));
        checkOutput("mr_f_donecnt", 32'(doneCount - doneBase), 32'd1);

`ifdef SERIAL_TX_PARITY_EN
        // Parity bit follows the LSB; three set bits give parity 1.
        tick(2);
        riseBase = riseCount;
        applyStimulus(23'h000007);
        tick(95);
        checkOutput("par_predone", 32'(done_tick), 32'd0);
        tick(1);
        checkOutput("par_done97", 32'(done_tick), 32'd1);
        tick(1);
        checkOutput("par_rises", 32'(riseCount - riseBase), 32'd24);
        checkOutput("par_lastbit", 32'(rxWord[0]), 32'd1);
        checkOutput("par_word", receivedFrame(), 32'h00000F);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
